// File: rtl/reg_seqtrigger_pkg.sv
// reg_seqtrigger shared definitions
// Register addresses, mode and FSM encodings, stage record.
package reg_seqtrigger_pkg;

   localparam logic [5:0] REG_CTRL_DEF   = 6'd54;
   localparam logic [5:0] REG_STAGE_DEF  = 6'd55;
   localparam logic [5:0] REG_STATUS_DEF = 6'd56;

   typedef enum logic [1:0] {
      MODE_RISE  = 2'b00,
      MODE_FALL  = 2'b01,
      MODE_BOTH  = 2'b10,
      MODE_LEVEL = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_FIRE = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef struct packed {
      logic [31:0] mask;
      mode_e       mode;
      logic        last;
      logic [15:0] tout;
   } stage_t;

   typedef struct packed {
      logic rearm;
      logic en;
   } ctrl_t;

   function automatic logic [31:0] low_ones(input int n);
      low_ones = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
   endfunction

endpackage

// File: rtl/reg_seqtrigger_if.sv
// reg_seqtrigger register bus
// Byte-wide register access plus length query.
interface reg_seqtrigger_if;
   import reg_seqtrigger_pkg::*;

   logic [5:0]  reg_address;
   logic [15:0] reg_bytecnt;
   logic [7:0]  reg_datai;
   logic [7:0]  reg_datao;
   logic [15:0] reg_size;
   logic        reg_read;
   logic        reg_write;
   logic        reg_addrvalid;
   logic [5:0]  reg_hypaddress;
   logic [15:0] reg_hyplen;
   logic        reg_stream;

   modport master (
      output reg_address, reg_bytecnt, reg_datai, reg_size,
      output reg_read, reg_write, reg_addrvalid, reg_hypaddress,
      input  reg_datao, reg_hyplen, reg_stream
   );

   modport slave (
      input  reg_address, reg_bytecnt, reg_datai, reg_size,
      input  reg_read, reg_write, reg_addrvalid, reg_hypaddress,
      output reg_datao, reg_hyplen, reg_stream
   );

endinterface

// File: rtl/reg_seqtrigger_sync.sv
// trig_sync_edge: source synchroniser and edge detect
// Rise/fall are registered so they line up with the delayed level copy.
module trig_sync_edge
   import reg_seqtrigger_pkg::*;
#(
   parameter int NCH = 16
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [NCH-1:0] src_i,
   output logic [NCH-1:0] rise_o,
   output logic [NCH-1:0] fall_o,
   output logic [NCH-1:0] level_o
);

   logic [NCH-1:0] sync1_q, sync1_d;
   logic [NCH-1:0] sync2_q, sync2_d;
   logic [NCH-1:0] dly_q, dly_d;
   logic [NCH-1:0] rise_q, rise_d;
   logic [NCH-1:0] fall_q, fall_d;

   // next values of the sync chain and edge vectors
   always_comb begin
      sync1_d = src_i;
      sync2_d = sync1_q;
      dly_d   = sync2_q;
      rise_d  = sync2_q & ~dly_q;
      fall_d  = ~sync2_q & dly_q;
   end

   // sync chain and edge registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         dly_q   <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         dly_q   <= dly_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign level_o = dly_q;

endmodule

// File: rtl/reg_seqtrigger.sv
// reg_seqtrigger: multi-stage sequenced trigger
// Register file, stage mux, timeout counter and sequencing FSM.
module reg_seqtrigger
   import reg_seqtrigger_pkg::*;
#(
   parameter int         NCH        = 16,
   parameter int         NSTAGE     = 4,
   parameter int         CNTW       = 16,
   parameter logic [5:0] REG_CTRL   = REG_CTRL_DEF,
   parameter logic [5:0] REG_STAGE  = REG_STAGE_DEF,
   parameter logic [5:0] REG_STATUS = REG_STATUS_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   reg_seqtrigger_if.slave  bus,
   input  logic [NCH-1:0]   sources_i,
   output logic             trig_out
);

   localparam int          SLEN    = 8 * NSTAGE;
   localparam logic [31:0] MASK_OK = low_ones(NCH);
   localparam logic [31:0] TOUT_32 = low_ones(CNTW);
   localparam logic [15:0] TOUT_OK = TOUT_32[15:0];

   logic [NCH-1:0] rise, fall, level;

   trig_sync_edge #(.NCH(NCH)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .src_i   (sources_i),
      .rise_o  (rise),
      .fall_o  (fall),
      .level_o (level)
   );

   ctrl_t            ctrl_q, ctrl_d;
   logic             clr;
   stage_t           stg_q [NSTAGE];
   stage_t           stg_d [NSTAGE];
   state_e           state_q, state_d;
   logic [2:0]       stage_q, stage_d;
   logic [CNTW-1:0]  tcnt_q, tcnt_d;
   logic             trig_q, trig_d;
   logic             fired_q, fired_d;
   logic             tmo_q, tmo_d;
   logic [15:0]      fcnt_q, fcnt_d;

   logic             wr_ctrl, wr_stg, rd_en;
   logic             stg_in;
   logic [2:0]       w_stage, w_fld;
   stage_t           cur, nxt, rd_s;
   logic [31:0]      rise_w, fall_w, lvl_w, cond;
   logic             match, at_end, tmo_en;
   logic [7:0]       status_b0;
   logic             unused_size;

   assign unused_size = ^bus.reg_size;
   assign stg_in  = bus.reg_bytecnt < 16'(SLEN);
   assign w_stage = bus.reg_bytecnt[5:3];
   assign w_fld   = bus.reg_bytecnt[2:0];
   assign rd_en   = bus.reg_read & bus.reg_addrvalid;
   assign wr_ctrl = bus.reg_write & bus.reg_addrvalid &
                    (bus.reg_address == REG_CTRL) &
                    (bus.reg_bytecnt == 16'd0);
   assign wr_stg  = bus.reg_write & bus.reg_addrvalid &
                    (bus.reg_address == REG_STAGE) &
                    stg_in & (state_q == ST_IDLE);

   // control register; clear is a one-shot strobe, never stored
   always_comb begin
      ctrl_d = ctrl_q;
      clr    = 1'b0;
      if (wr_ctrl) begin
         ctrl_d.en    = bus.reg_datai[0];
         ctrl_d.rearm = bus.reg_datai[1];
         clr          = bus.reg_datai[2];
      end
   end

   // stage table writes, unimplemented mask/timeout bits forced to 0
   always_comb begin
      for (int s = 0; s < NSTAGE; s++) begin
         stg_d[s] = stg_q[s];
         if (wr_stg && int'(w_stage) == s) begin
            case (w_fld)
               3'd0: stg_d[s].mask[7:0]   = bus.reg_datai;
               3'd1: stg_d[s].mask[15:8]  = bus.reg_datai;
               3'd2: stg_d[s].mask[23:16] = bus.reg_datai;
               3'd3: stg_d[s].mask[31:24] = bus.reg_datai;
               3'd4: begin
                  stg_d[s].mode = mode_e'(bus.reg_datai[1:0]);
                  stg_d[s].last = bus.reg_datai[7];
               end
               3'd5: stg_d[s].tout[7:0]  = bus.reg_datai;
               3'd6: stg_d[s].tout[15:8] = bus.reg_datai;
               default: ;
            endcase
         end
         stg_d[s].mask = stg_d[s].mask & MASK_OK;
         stg_d[s].tout = stg_d[s].tout & TOUT_OK;
      end
   end

   // stage mux: current, next and bus-addressed stage records
   always_comb begin
      cur  = '0;
      nxt  = '0;
      rd_s = '0;
      for (int s = 0; s < NSTAGE; s++) begin
         if (int'(stage_q) == s)     cur  = stg_q[s];
         if (int'(stage_q) + 1 == s) nxt  = stg_q[s];
         if (int'(w_stage) == s)     rd_s = stg_q[s];
      end
   end

   // per-stage match: OR over masked channels of the mode condition
   always_comb begin
      rise_w = '0;
      fall_w = '0;
      lvl_w  = '0;
      rise_w[NCH-1:0] = rise;
      fall_w[NCH-1:0] = fall;
      lvl_w[NCH-1:0]  = level;
      cond = '0;
      case (cur.mode)
         MODE_RISE:  cond = rise_w;
         MODE_FALL:  cond = fall_w;
         MODE_BOTH:  cond = rise_w | fall_w;
         MODE_LEVEL: cond = lvl_w;
         default:    cond = '0;
      endcase
      match  = |(cur.mask & cond);
      at_end = int'(stage_q) == NSTAGE - 1;
      tmo_en = (stage_q != 3'd0) && (cur.tout != 16'd0);
   end

   // sequencing FSM next state; a match beats timeout expiry
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      tcnt_d  = tcnt_q;
      trig_d  = 1'b0;
      fired_d = fired_q;
      tmo_d   = tmo_q;
      fcnt_d  = fcnt_q;
      if (!ctrl_q.en) begin
         state_d = ST_IDLE;
         stage_d = 3'd0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT;
               stage_d = 3'd0;
            end
            ST_WAIT: begin
               if (match) begin
                  if (cur.last || at_end) begin
                     state_d = ST_FIRE;
                     trig_d  = 1'b1;
                     fired_d = 1'b1;
                     if (fcnt_q != 16'hFFFF)
                        fcnt_d = fcnt_q + 16'd1;
                  end else begin
                     stage_d = stage_q + 3'd1;
                     tcnt_d  = nxt.tout[CNTW-1:0];
                  end
               end else if (tmo_en) begin
                  if (tcnt_q <= CNTW'(2)) begin
                     stage_d = 3'd0;
                     tmo_d   = 1'b1;
                  end else begin
                     tcnt_d = tcnt_q - CNTW'(1);
                  end
               end
            end
            ST_FIRE: begin
               state_d = ctrl_q.rearm ? ST_WAIT : ST_DONE;
               stage_d = 3'd0;
            end
            ST_DONE: ;
         endcase
      end
      if (clr) begin
         fired_d = 1'b0;
         tmo_d   = 1'b0;
         fcnt_d  = 16'd0;
      end
   end

   // all state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q  <= '0;
         for (int s = 0; s < NSTAGE; s++) stg_q[s] <= '0;
         state_q <= ST_IDLE;
         stage_q <= 3'd0;
         tcnt_q  <= '0;
         trig_q  <= 1'b0;
         fired_q <= 1'b0;
         tmo_q   <= 1'b0;
         fcnt_q  <= 16'd0;
      end else begin
         ctrl_q  <= ctrl_d;
         for (int s = 0; s < NSTAGE; s++) stg_q[s] <= stg_d[s];
         state_q <= state_d;
         stage_q <= stage_d;
         tcnt_q  <= tcnt_d;
         trig_q  <= trig_d;
         fired_q <= fired_d;
         tmo_q   <= tmo_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign trig_out  = trig_q;
   assign status_b0 = {fired_q, tmo_q, state_q, 1'b0, stage_q};

   // combinational read mux
   always_comb begin
      bus.reg_datao = 8'd0;
      if (rd_en) begin
         if (bus.reg_address == REG_CTRL) begin
            if (bus.reg_bytecnt == 16'd0)
               bus.reg_datao = {6'd0, ctrl_q.rearm, ctrl_q.en};
         end else if (bus.reg_address == REG_STAGE) begin
            if (stg_in) begin
               case (w_fld)
                  3'd0: bus.reg_datao = rd_s.mask[7:0];
                  3'd1: bus.reg_datao = rd_s.mask[15:8];
                  3'd2: bus.reg_datao = rd_s.mask[23:16];
                  3'd3: bus.reg_datao = rd_s.mask[31:24];
                  3'd4: bus.reg_datao = {rd_s.last, 5'd0, rd_s.mode};
                  3'd5: bus.reg_datao = rd_s.tout[7:0];
                  3'd6: bus.reg_datao = rd_s.tout[15:8];
                  default: bus.reg_datao = 8'd0;
               endcase
            end
         end else if (bus.reg_address == REG_STATUS) begin
            case (bus.reg_bytecnt)
               16'd0:   bus.reg_datao = status_b0;
               16'd1:   bus.reg_datao = fcnt_q[7:0];
               16'd2:   bus.reg_datao = fcnt_q[15:8];
               default: bus.reg_datao = 8'd0;
            endcase
         end
      end
   end

   // register length query
   always_comb begin
      bus.reg_hyplen = 16'd0;
      if (bus.reg_hypaddress == REG_CTRL)
         bus.reg_hyplen = 16'd1;
      else if (bus.reg_hypaddress == REG_STAGE)
         bus.reg_hyplen = 16'(SLEN);
      else if (bus.reg_hypaddress == REG_STATUS)
         bus.reg_hyplen = 16'd4;
   end

   assign bus.reg_stream = 1'b0;

endmodule

// File: tb/tb_reg_seqtrigger.sv
// tb_reg_seqtrigger: directed bench for reg_seqtrigger
// Register vector table plus hand-built sequence scenarios.
module tb_reg_seqtrigger;
   import reg_seqtrigger_pkg::*;

   localparam logic [5:0] A_CTRL = REG_CTRL_DEF;
   localparam logic [5:0] A_STG  = REG_STAGE_DEF;
   localparam logic [5:0] A_STAT = REG_STATUS_DEF;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] src = 16'd0;
   logic        trig;

   reg_seqtrigger_if bus();

   reg_seqtrigger dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .sources_i (src),
      .trig_out  (trig)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   // count trig_out pulses just after each clock edge
   always @(posedge clk) begin
      #1;
      if (trig === 1'b1) pulses++;
   end

   typedef struct {
      logic        wr;
      logic [5:0]  a;
      logic [15:0] b;
      logic [7:0]  d;
      string       nm;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic wr, input logic [5:0] a,
                      input logic [15:0] b, input logic [7:0] d,
                      input string nm);
      vec_t v;
      v.wr = wr; v.a = a; v.b = b; v.d = d; v.nm = nm;
      tbl.push_back(v);
   endtask

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic reg_wr(input logic [5:0] a, input logic [15:0] b,
                         input logic [7:0] d);
      @(negedge clk);
      bus.reg_address   = a;
      bus.reg_bytecnt   = b;
      bus.reg_datai     = d;
      bus.reg_write     = 1'b1;
      bus.reg_addrvalid = 1'b1;
      @(negedge clk);
      bus.reg_write     = 1'b0;
      bus.reg_addrvalid = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [5:0] a,
                         input logic [15:0] b, input logic [7:0] exp);
      logic [7:0] v;
      @(negedge clk);
      bus.reg_address   = a;
      bus.reg_bytecnt   = b;
      bus.reg_read      = 1'b1;
      bus.reg_addrvalid = 1'b1;
      #1;
      v = bus.reg_datao;
      bus.reg_read      = 1'b0;
      bus.reg_addrvalid = 1'b0;
      check(nm, 32'(v), 32'(exp));
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_stage(input int s, input logic [31:0] m,
                            input logic [7:0] md, input logic [15:0] t);
      logic [15:0] base;
      base = 16'(8 * s);
      reg_wr(A_STG, base + 16'd0, m[7:0]);
      reg_wr(A_STG, base + 16'd1, m[15:8]);
      reg_wr(A_STG, base + 16'd2, m[23:16]);
      reg_wr(A_STG, base + 16'd3, m[31:24]);
      reg_wr(A_STG, base + 16'd4, md);
      reg_wr(A_STG, base + 16'd5, t[7:0]);
      reg_wr(A_STG, base + 16'd6, t[15:8]);
   endtask

   task automatic disable_clr();
      reg_wr(A_CTRL, 16'd0, 8'h04);
      wait_n(2);
   endtask

   // two-stage: src1 rise, then src2 fall within timeout 10
   task automatic arm2();
      disable_clr();
      src = 16'h0004;
      set_stage(0, 32'h2, 8'h00, 16'd0);
      set_stage(1, 32'h4, 8'h81, 16'd10);
      reg_wr(A_CTRL, 16'd0, 8'h01);
      wait_n(4);
   endtask

   task automatic run_gap(input int g, input int exp_p,
                          input logic [7:0] exp_b0, input string nm);
      int base;
      arm2();
      base = pulses;
      @(negedge clk);
      src[1] = 1'b1;
      repeat (g) @(negedge clk);
      src[2] = 1'b0;
      wait_n(10);
      check({nm, "_pulses"}, 32'(pulses - base), 32'(exp_p));
      rd_chk({nm, "_status"}, A_STAT, 16'd0, exp_b0);
   endtask

   initial begin
      int first, hits, base;
      logic found;

      bus.reg_address    = '0;
      bus.reg_bytecnt    = '0;
      bus.reg_datai      = '0;
      bus.reg_size       = '0;
      bus.reg_read       = 1'b0;
      bus.reg_write      = 1'b0;
      bus.reg_addrvalid  = 1'b0;
      bus.reg_hypaddress = '0;

      wait_n(3);
      check("rst_trig", 32'(trig), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      rd_chk("rst_stat0", A_STAT, 16'd0, 8'h00);
      rd_chk("rst_stat1", A_STAT, 16'd1, 8'h00);

      // register access table
      add(0, A_STG,   0, 8'h00, "rst_stg0");
      add(0, A_STG,  16, 8'h00, "rst_stg16");
      add(1, A_STG,   0, 8'hA5, "");
      add(0, A_STG,   0, 8'hA5, "mask_b0");
      add(1, A_STG,   1, 8'h3C, "");
      add(0, A_STG,   1, 8'h3C, "mask_b1");
      add(1, A_STG,   2, 8'hFF, "");
      add(0, A_STG,   2, 8'h00, "mask_b2_ign");
      add(1, A_STG,   4, 8'hFF, "");
      add(0, A_STG,   4, 8'h83, "mode_b4");
      add(1, A_STG,   5, 8'h34, "");
      add(1, A_STG,   6, 8'h12, "");
      add(0, A_STG,   5, 8'h34, "tout_lo");
      add(0, A_STG,   6, 8'h12, "tout_hi");
      add(1, A_STG,   7, 8'hFF, "");
      add(0, A_STG,   7, 8'h00, "rsvd_b7");
      add(1, A_STG,  24, 8'h77, "");
      add(0, A_STG,  24, 8'h77, "stg3_mask");
      add(1, A_STG,  32, 8'h99, "");
      add(0, A_STG,  32, 8'h00, "b32_rd");
      add(0, A_STG,   0, 8'hA5, "b32_noalias");
      add(0, A_CTRL,  0, 8'h00, "ctrl_rst");
      add(1, A_CTRL,  0, 8'h06, "");
      add(0, A_CTRL,  0, 8'h02, "ctrl_rearm");
      add(1, A_CTRL,  0, 8'h00, "");
      add(0, 6'd20,   0, 8'h00, "unmapped");
      add(0, A_STAT,  3, 8'h00, "stat_b3");
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].wr)
            reg_wr(tbl[i].a, tbl[i].b, tbl[i].d);
         else
            rd_chk(tbl[i].nm, tbl[i].a, tbl[i].b, tbl[i].d);
      end

      // length query, stream tie-off and read gating
      bus.reg_hypaddress = A_STG;  #1;
      check("hyp_stage", 32'(bus.reg_hyplen), 32'd32);
      bus.reg_hypaddress = A_CTRL; #1;
      check("hyp_ctrl", 32'(bus.reg_hyplen), 32'd1);
      bus.reg_hypaddress = A_STAT; #1;
      check("hyp_status", 32'(bus.reg_hyplen), 32'd4);
      bus.reg_hypaddress = 6'd20;  #1;
      check("hyp_none", 32'(bus.reg_hyplen), 32'd0);
      check("stream", 32'(bus.reg_stream), 32'd0);
      @(negedge clk);
      bus.reg_address   = A_STG;
      bus.reg_bytecnt   = 16'd0;
      bus.reg_addrvalid = 1'b1;
      bus.reg_read      = 1'b0;
      #1;
      check("gate_noread", 32'(bus.reg_datao), 32'd0);
      bus.reg_addrvalid = 1'b0;
      bus.reg_read      = 1'b1;
      #1;
      check("gate_noav", 32'(bus.reg_datao), 32'd0);
      bus.reg_read      = 1'b0;

      // single-stage rise, latency and DONE
      disable_clr();
      set_stage(0, 32'h1, 8'h80, 16'd0);
      reg_wr(A_CTRL, 16'd0, 8'h01);
      wait_n(3);
      rd_chk("t1_wait", A_STAT, 16'd0, 8'h10);
      @(negedge clk);
      src[0] = 1'b1;
      first = 0;
      hits = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (trig) begin
            if (first == 0) first = k;
            hits++;
         end
      end
      check("t1_latency", 32'(first), 32'd4);
      check("t1_width", 32'(hits), 32'd1);
      rd_chk("t1_status", A_STAT, 16'd0, 8'hB0);
      rd_chk("t1_count", A_STAT, 16'd1, 8'h01);
      src[0] = 1'b0;

      // two-stage timing windows around the timeout of 10
      run_gap(5,  1, 8'hB0, "t2_gap5");
      run_gap(12, 0, 8'h50, "t2_gap12");
      run_gap(9,  1, 8'hB0, "t3_gap9");
      run_gap(10, 0, 8'h50, "t3_gap10");

      // auto re-arm
      disable_clr();
      src = 16'h0000;
      set_stage(0, 32'h1, 8'h80, 16'd0);
      reg_wr(A_CTRL, 16'd0, 8'h03);
      wait_n(3);
      base = pulses;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         src[0] = 1'b1;
         wait_n(2);
         src[0] = 1'b0;
         wait_n(4);
      end
      wait_n(3);
      check("t4_pulses", 32'(pulses - base), 32'd3);
      rd_chk("t4_count_lo", A_STAT, 16'd1, 8'h03);
      rd_chk("t4_count_hi", A_STAT, 16'd2, 8'h00);
      rd_chk("t4_status", A_STAT, 16'd0, 8'h90);

      // stage writes dropped outside IDLE
      reg_wr(A_STG, 16'd0, 8'h55);
      rd_chk("t5_wr_wait", A_STG, 16'd0, 8'h01);

      // disable mid-sequence
      disable_clr();
      src = 16'h0000;
      set_stage(0, 32'h1, 8'h00, 16'd0);
      set_stage(1, 32'h4, 8'h81, 16'd10);
      reg_wr(A_CTRL, 16'd0, 8'h01);
      wait_n(3);
      @(negedge clk);
      src[0] = 1'b1;
      wait_n(5);
      rd_chk("t5_stage1", A_STAT, 16'd0, 8'h11);
      reg_wr(A_CTRL, 16'd0, 8'h00);
      wait_n(2);
      rd_chk("t5_idle", A_STAT, 16'd0, 8'h00);

      // reset while in FIRE
      disable_clr();
      src = 16'h0000;
      set_stage(0, 32'h1, 8'h80, 16'd0);
      wait_n(3);
      reg_wr(A_CTRL, 16'd0, 8'h01);
      wait_n(3);
      @(negedge clk);
      src[0] = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(posedge clk);
         #1;
         if (trig) found = 1'b1;
      end
      check("t5_fire_seen", 32'(found), 32'd1);
      reset_n = 1'b0;
      #1;
      check("t5_rst_trig", 32'(trig), 32'd0);
      rd_chk("t5_rst_stat", A_STAT, 16'd0, 8'h00);
      rd_chk("t5_rst_ctrl", A_CTRL, 16'd0, 8'h00);
      src[0] = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      wait_n(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
